// File: rtl/d_debounce_sync.sv
// Conditions a raw asynchronous level into a synchronized, debounced level
// with single-cycle rise/fall pulses and a settling indicator.
module d_debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    output logic q,
    output logic rise,
    output logic fall,
    output logic settling
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("d_debounce_sync: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
            $error("d_debounce_sync: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   d_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = D;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_sync = sync_q[SYNC_STAGES-1];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_q;
    logic             rise_q;
    logic             fall_q;
    logic             settling_q;

    // Pulses default low each cycle so they can only ever last one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            q_q        <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            settling_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (d_sync) begin
                        state_q    <= ST_CHK_HI;
                        cnt_q      <= CNT_ONE;
                        settling_q <= 1'b1;
                    end
                end
                ST_CHK_HI: begin
                    if (!d_sync) begin
                        state_q    <= ST_LOW;
                        cnt_q      <= '0;
                        settling_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_HIGH;
                        cnt_q      <= '0;
                        q_q        <= 1'b1;
                        rise_q     <= 1'b1;
                        settling_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!d_sync) begin
                        state_q    <= ST_CHK_LO;
                        cnt_q      <= CNT_ONE;
                        settling_q <= 1'b1;
                    end
                end
                ST_CHK_LO: begin
                    if (d_sync) begin
                        state_q    <= ST_HIGH;
                        cnt_q      <= '0;
                        settling_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_LOW;
                        cnt_q      <= '0;
                        q_q        <= 1'b0;
                        fall_q     <= 1'b1;
                        settling_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_LOW;
                    cnt_q      <= '0;
                    q_q        <= 1'b0;
                    settling_q <= 1'b0;
                end
            endcase
        end
    end

    assign q        = q_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign settling = settling_q;

endmodule

// File: tb/tb_d_debounce_sync.sv
// Directed bench for d_debounce_sync: run-length reference model checked every
// cycle, plus literal edge-numbered expectations for each scenario.
module tb_d_debounce_sync;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk;
    logic rst;
    logic D;
    logic q;
    logic rise;
    logic fall;
    logic settling;

    int check_cnt = 0;
    int pass_cnt  = 0;

    d_debounce_sync #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .D       (D),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .settling(settling)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: d_sync is D delayed SYNC samples; q flips once DEB consecutive
    // samples have disagreed with it.
    bit   m_dq[$];
    int   m_run;
    logic m_q, m_rise, m_fall, m_set;
    bit   m_valid = 1'b0;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        check_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic model_update(input logic d, input logic r);
        bit v;
        if (r) begin
            m_dq.delete();
            for (int i = 0; i < SYNC; i++) m_dq.push_back(1'b0);
            m_q = 1'b0; m_run = 0; m_rise = 1'b0; m_fall = 1'b0; m_set = 1'b0;
            m_valid = 1'b1;
        end else begin
            v = m_dq[SYNC-1];
            void'(m_dq.pop_back());
            m_dq.push_front(d);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (v != m_q) begin
                m_run++;
                if (m_run == DEB) begin
                    m_q    = v;
                    m_rise = v;
                    m_fall = !v;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_set = (m_run != 0);
        end
    endtask

    task automatic tick(input logic d, input logic r);
        D   = d;
        rst = r;
        @(posedge clk);
        model_update(d, r);
        #1;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_q", q, m_q);
            check("model_rise", rise, m_rise);
            check("model_fall", fall, m_fall);
            check("model_settling", settling, m_set);
            check("rise_fall_excl", rise & fall, 1'b0);
            check("pulse_gap", (rise | fall) & prev_pulse, 1'b0);
            prev_pulse <= rise | fall;
        end
    end

    int rise_seen;

    initial begin
        D   = 1'b1;
        rst = 1'b1;

        // Reset held with D=1
        for (int e = 1; e <= 2; e++) begin
            tick(1'b1, 1'b1);
            check("reset_q", q, 1'b0);
            check("reset_rise", rise, 1'b0);
            check("reset_fall", fall, 1'b0);
            check("reset_settling", settling, 1'b0);
        end
        for (int e = 1; e <= 3; e++) tick(1'b0, 1'b0);

        // Clean rise
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b0);
            check("rise_q", q, e >= 6);
            check("rise_pulse", rise, e == 6);
            check("rise_settling", settling, e >= 3 && e <= 5);
            check("rise_nofall", fall, 1'b0);
        end

        // Clean fall
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0, 1'b0);
            check("fall_q", q, e < 6);
            check("fall_pulse", fall, e == 6);
            check("fall_norise", rise, 1'b0);
        end

        // Glitch of three cycles from LOW
        for (int e = 1; e <= 8; e++) begin
            tick(e <= 3, 1'b0);
            check("glitch_q", q, 1'b0);
            check("glitch_rise", rise, 1'b0);
            check("glitch_settling", settling, e >= 3 && e <= 5);
        end

        // Bounce: ten toggles then hold high
        rise_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2) == 0, 1'b0);
            check("bounce_q", q, 1'b0);
            if (rise) rise_seen++;
        end
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b0);
            check("bounce_hold_q", q, e >= 6);
            check("bounce_hold_rise", rise, e == 6);
            if (rise) rise_seen++;
        end
        check("bounce_one_rise", rise_seen == 1, 1'b1);

        // Back to LOW, then reset while checking a rise
        for (int e = 1; e <= 8; e++) tick(1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) tick(1'b1, 1'b0);
        check("midsettle_pre_settling", settling, 1'b1);
        tick(1'b1, 1'b1);
        check("midsettle_rst_q", q, 1'b0);
        check("midsettle_rst_settling", settling, 1'b0);
        check("midsettle_rst_rise", rise, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b0);
            check("midsettle_q", q, e >= 6);
            check("midsettle_rise", rise, e == 6);
        end

        tick(1'b1, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
